upe_addsub_pipe: RTL and testbench



---
 rtl/upe_pkg.sv | 14 +
 rtl/upe_addsub_pipe_if.sv | 31 +++
 rtl/upe_addsub_pipe_add_limb.sv | 71 +++++++
 rtl/upe_addsub_pipe.sv | 128 ++++++++++++
 tb/tb_upe_addsub_pipe.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/upe_pkg.sv
// Shared definitions for the UPE datapath.
// UPE_LIMB is the limb width that one pipeline adder stage handles.
// upe_nlimb() gives the number of limbs, and so the number of stages, for an operand width.
package upe_pkg;

  localparam int UPE_LIMB = 32;

  typedef logic [UPE_LIMB-1:0] upe_limb_t;

  function automatic int upe_nlimb(input int width);
    return width / UPE_LIMB;
  endfunction

endpackage

// File: rtl/upe_addsub_pipe_if.sv
// Valid/ready bus for the pipelined add/sub unit.
// Input side : in_valid/in_ready handshake, operands in_a/in_b, in_sub (mode), in_cin.
// Output side: out_valid/out_ready handshake, out_sum, out_cout, out_ovf.
// master = the producer/consumer around the unit; slave = the unit itself.
interface upe_addsub_pipe_if #(
  parameter int WIDTH = 64
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

endinterface

// File: rtl/upe_addsub_pipe_add_limb.sv
// One registered 32-bit limb stage of the pipelined adder/subtractor.
// Inputs : a, b (limb operands), sub (invert b), cin (carry into this limb),
//          valid_in (beat valid), hold (freeze all registers).
// Outputs: sum, cout, msb_a, msb_b (MSB of b after optional inversion), valid;
//          all registered and cleared by rst.
module upe_add_limb
  import upe_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  upe_limb_t a,
  input  upe_limb_t b,
  input  logic      sub,
  input  logic      cin,
  input  logic      valid_in,
  input  logic      hold,
  output upe_limb_t sum,
  output logic      cout,
  output logic      msb_a,
  output logic      msb_b,
  output logic      valid
);

  upe_limb_t         b_eff;
  logic [UPE_LIMB:0] total;
  upe_limb_t         sum_d, sum_q;
  logic              cout_d, cout_q;
  logic              msb_a_d, msb_a_q;
  logic              msb_b_d, msb_b_q;
  logic              valid_d, valid_q;

  always_comb begin
    b_eff   = sub ? ~b : b;
    total   = {1'b0, a} + {1'b0, b_eff} + {{UPE_LIMB{1'b0}}, cin};
    sum_d   = sum_q;
    cout_d  = cout_q;
    msb_a_d = msb_a_q;
    msb_b_d = msb_b_q;
    valid_d = valid_q;
    if (!hold) begin
      sum_d   = total[UPE_LIMB-1:0];
      cout_d  = total[UPE_LIMB];
      msb_a_d = a[UPE_LIMB-1];
      msb_b_d = b_eff[UPE_LIMB-1];
      valid_d = valid_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      msb_a_q <= 1'b0;
      msb_b_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      msb_a_q <= msb_a_d;
      msb_b_q <= msb_b_d;
      valid_q <= valid_d;
    end
  end

  assign sum   = sum_q;
  assign cout  = cout_q;
  assign msb_a = msb_a_q;
  assign msb_b = msb_b_q;
  assign valid = valid_q;

endmodule

// File: rtl/upe_addsub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor, one 32-bit limb per stage, carry registered
// between stages. Accepts one beat per cycle on a valid/ready bus.
// Ports: clk, rst (synchronous, active-high), bus (slave side of upe_addsub_pipe_if:
//        in_valid/in_ready/in_a/in_b/in_sub/in_cin, out_valid/out_ready/out_sum/out_cout/out_ovf).
// Limb k of the operands is delayed k cycles (skew) so it meets the carry from limb k-1;
// the sum of limb k is delayed NLIMB-1-k cycles (deskew) so all limbs leave together.
// WIDTH must be a multiple of 32 and match the bus WIDTH.
module upe_addsub_pipe
  import upe_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input logic               clk,
  input logic               rst,
  upe_addsub_pipe_if.slave  bus
);

  localparam int NLIMB = upe_nlimb(WIDTH);
  localparam int LAST  = NLIMB - 1;
  localparam int SKW   = 2 * UPE_LIMB + 1;  // {sub, a limb, b limb}

  logic       stall;
  upe_limb_t  st_a     [NLIMB];
  upe_limb_t  st_b     [NLIMB];
  logic       st_sub   [NLIMB];
  logic       st_cin   [NLIMB];
  upe_limb_t  st_sum   [NLIMB];
  logic       st_cout  [NLIMB];
  logic       st_msb_a [NLIMB];
  logic       st_msb_b [NLIMB];
  logic       st_valid [NLIMB];
  upe_limb_t  res_limb [NLIMB];
  logic [WIDTH-1:0] sum_cat;

  // Freezing every register while the output is blocked keeps beats aligned
  // with their carries across the skew/deskew chains.
  assign stall        = st_valid[LAST] & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  for (genvar gi = 0; gi < NLIMB; gi++) begin : g_limb
    localparam int DD = LAST - gi;
    logic [SKW-1:0] skew_in;

    assign skew_in = {bus.in_sub, bus.in_a[gi*UPE_LIMB +: UPE_LIMB], bus.in_b[gi*UPE_LIMB +: UPE_LIMB]};

    if (gi == 0) begin : g_noskew
      assign {st_sub[gi], st_a[gi], st_b[gi]} = skew_in;
      // Subtract forces a carry-in of 1 to form the two's complement of B.
      assign st_cin[gi] = bus.in_sub | bus.in_cin;
    end else begin : g_skew
      logic [SKW-1:0] skew_d [gi];
      logic [SKW-1:0] skew_q [gi];

      always_comb begin
        skew_d[0] = skew_in;
        for (int j = 1; j < gi; j++) begin
          skew_d[j] = skew_q[j-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          skew_q <= '{default: '0};
        end else if (!stall) begin
          skew_q <= skew_d;
        end
      end

      assign {st_sub[gi], st_a[gi], st_b[gi]} = skew_q[gi-1];
      assign st_cin[gi] = st_cout[gi-1];
    end

    upe_add_limb u_limb (
      .clk      (clk),
      .rst      (rst),
      .a        (st_a[gi]),
      .b        (st_b[gi]),
      .sub      (st_sub[gi]),
      .cin      (st_cin[gi]),
      .valid_in ((gi == 0) ? bus.in_valid : st_valid[(gi == 0) ? 0 : gi-1]),
      .hold     (stall),
      .sum      (st_sum[gi]),
      .cout     (st_cout[gi]),
      .msb_a    (st_msb_a[gi]),
      .msb_b    (st_msb_b[gi]),
      .valid    (st_valid[gi])
    );

    if (DD == 0) begin : g_nodeskew
      assign res_limb[gi] = st_sum[gi];
    end else begin : g_deskew
      upe_limb_t dsk_d [DD];
      upe_limb_t dsk_q [DD];

      always_comb begin
        dsk_d[0] = st_sum[gi];
        for (int j = 1; j < DD; j++) begin
          dsk_d[j] = dsk_q[j-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          dsk_q <= '{default: '0};
        end else if (!stall) begin
          dsk_q <= dsk_d;
        end
      end

      assign res_limb[gi] = dsk_q[DD-1];
    end
  end

  always_comb begin
    sum_cat = '0;
    for (int k = 0; k < NLIMB; k++) begin
      sum_cat[k*UPE_LIMB +: UPE_LIMB] = res_limb[k];
    end
  end

  assign bus.out_sum   = sum_cat;
  assign bus.out_valid = st_valid[LAST];
  assign bus.out_cout  = st_cout[LAST];
  // Signed overflow: both effective operands share a sign the result does not.
  assign bus.out_ovf   = (st_msb_a[LAST] == st_msb_b[LAST]) &
                         (st_sum[LAST][UPE_LIMB-1] != st_msb_a[LAST]);

endmodule

// File: tb/tb_upe_addsub_pipe.sv
module tb_upe_addsub_pipe;
  import upe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular arithmetic. Returns {cout, ovf, sum}.
  function automatic logic [129:0] ref_model(input int w, input logic [127:0] a, input logic [127:0] b,
                                             input logic sub, input logic cin);
    logic [127:0] mask, am, bm, sm;
    logic [128:0] tot;
    logic         co, ov, bsign;
    mask = (w >= 128) ? {128{1'b1}} : ((128'd1 << w) - 128'd1);
    am   = a & mask;
    bm   = b & mask;
    if (sub) begin
      sm    = (am - bm) & mask;
      co    = (am >= bm);
      bsign = ~bm[w-1];
    end else begin
      tot   = {1'b0, am} + {1'b0, bm} + {128'd0, cin};
      sm    = tot[127:0] & mask;
      co    = tot[w];
      bsign = bm[w-1];
    end
    ov = (am[w-1] == bsign) && (sm[w-1] != am[w-1]);
    return {co, ov, sm};
  endfunction

  // ---------------- WIDTH=64 directed DUT ----------------
  logic rst64;
  upe_addsub_pipe_if #(.WIDTH(64)) bus64 ();
  upe_addsub_pipe #(.WIDTH(64)) u_dut64 (.clk(clk), .rst(rst64), .bus(bus64));

  task automatic run_one64(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic sub, input logic cin,
                           input logic [63:0] es, input logic ec, input logic eo);
    int cnt;
    @(posedge clk); #1;
    bus64.in_valid = 1'b1; bus64.in_a = a; bus64.in_b = b;
    bus64.in_sub = sub; bus64.in_cin = cin; bus64.out_ready = 1'b1;
    @(negedge clk);
    check_value({tag, "_rdy"}, bus64.in_ready, 1);
    @(posedge clk); #1;
    bus64.in_valid = 1'b0;
    cnt = 1;
    @(negedge clk);
    while (!bus64.out_valid && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check_value({tag, "_lat"}, cnt, 2);
    check_value({tag, "_sum"}, bus64.out_sum, es);
    check_value({tag, "_cout"}, bus64.out_cout, ec);
    check_value({tag, "_ovf"}, bus64.out_ovf, eo);
    $display("txn %s a=%h b=%h sub=%0d sum=%h cout=%0d ovf=%0d", tag, a, b, sub,
             bus64.out_sum, bus64.out_cout, bus64.out_ovf);
  endtask

  // ---------------- WIDTH=32 / WIDTH=128 random sweep ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
    localparam int W  = (gi == 0) ? 32 : 128;
    localparam int NL = W / 32;
    logic rst_w;
    logic done = 1'b0;
    upe_addsub_pipe_if #(.WIDTH(W)) bus_w ();
    upe_addsub_pipe #(.WIDTH(W)) u_dut (.clk(clk), .rst(rst_w), .bus(bus_w));

    initial begin
      logic [129:0] exp_q [$];
      logic [129:0] e;
      logic [127:0] ra, rb;
      int           cnt;
      rst_w = 1'b1;
      bus_w.in_valid = 1'b0; bus_w.in_a = '0; bus_w.in_b = '0;
      bus_w.in_sub = 1'b0; bus_w.in_cin = 1'b0; bus_w.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_w = 1'b0;
      @(negedge clk);
      check_value($sformatf("w%0d_rst_valid", W), bus_w.out_valid, 0);
      check_value($sformatf("w%0d_rst_sum", W), bus_w.out_sum, 0);
      check_value($sformatf("w%0d_rst_rdy", W), bus_w.in_ready, 1);

      // Single beat latency
      @(posedge clk); #1;
      for (int j = 0; j < 4; j++) begin ra[j*32 +: 32] = $urandom; rb[j*32 +: 32] = $urandom; end
      bus_w.in_valid = 1'b1; bus_w.in_a = ra[W-1:0]; bus_w.in_b = rb[W-1:0];
      bus_w.in_sub = 1'b1; bus_w.in_cin = 1'b0;
      e = ref_model(W, ra, rb, 1'b1, 1'b0);
      @(posedge clk); #1;
      bus_w.in_valid = 1'b0;
      cnt = 1;
      @(negedge clk);
      while (!bus_w.out_valid && cnt < 10) begin
        @(negedge clk);
        cnt++;
      end
      check_value($sformatf("w%0d_lat", W), cnt, NL);
      check_value($sformatf("w%0d_lat_sum", W), bus_w.out_sum, e[127:0]);
      $display("txn w%0d latency=%0d sum=%h", W, cnt, bus_w.out_sum);

      // Random traffic with random backpressure, then drain
      for (int c = 0; c < 330; c++) begin
        @(posedge clk); #1;
        for (int j = 0; j < 4; j++) begin ra[j*32 +: 32] = $urandom; rb[j*32 +: 32] = $urandom; end
        bus_w.in_valid  = (c < 300) && ($urandom_range(0, 3) != 0);
        bus_w.in_a      = ra[W-1:0];
        bus_w.in_b      = rb[W-1:0];
        bus_w.in_sub    = $urandom_range(0, 1) != 0;
        bus_w.in_cin    = $urandom_range(0, 1) != 0;
        bus_w.out_ready = (c >= 300) || ($urandom_range(0, 3) != 0);
        @(negedge clk);
        check_value($sformatf("w%0d_in_ready", W), bus_w.in_ready,
                    !(bus_w.out_valid && !bus_w.out_ready));
        if (bus_w.out_valid) begin
          if (exp_q.size() == 0) begin
            check_value($sformatf("w%0d_spurious", W), bus_w.out_valid, 0);
          end else begin
            e = exp_q[0];
            check_value($sformatf("w%0d_sum", W), bus_w.out_sum, e[127:0]);
            check_value($sformatf("w%0d_cout", W), bus_w.out_cout, e[129]);
            check_value($sformatf("w%0d_ovf", W), bus_w.out_ovf, e[128]);
            if (bus_w.out_ready) begin
              $display("txn w%0d out sum=%h cout=%0d ovf=%0d", W, bus_w.out_sum, bus_w.out_cout, bus_w.out_ovf);
              void'(exp_q.pop_front());
            end
          end
        end
        if (bus_w.in_valid && bus_w.in_ready)
          exp_q.push_back(ref_model(W, ra, rb, bus_w.in_sub, bus_w.in_cin));
      end
      check_value($sformatf("w%0d_drained", W), exp_q.size(), 0);
      done = 1'b1;
    end
  end

  // ---------------- main directed sequence ----------------
  initial begin
    logic [63:0]  sa [4];
    logic [63:0]  sb [4];
    logic         ss [4];
    logic         sc [4];
    logic [129:0] se [4];
    logic [63:0]  kk;
    int           k, idx, w;
    logic         exp_v;

    rst64 = 1'b1;
    bus64.in_valid = 1'b0; bus64.in_a = '0; bus64.in_b = '0;
    bus64.in_sub = 1'b0; bus64.in_cin = 1'b0; bus64.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst64 = 1'b0;
    @(negedge clk);
    check_value("rst_valid", bus64.out_valid, 0);
    check_value("rst_sum", bus64.out_sum, 0);
    check_value("rst_cout", bus64.out_cout, 0);
    check_value("rst_ovf", bus64.out_ovf, 0);
    check_value("rst_rdy", bus64.in_ready, 1);

    run_one64("carry_limb", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0);
    run_one64("sub_borrow", 64'd0, 64'd1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_one64("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    run_one64("add_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0);
    run_one64("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);

    // Back-to-back stream of 8 beats
    k = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      bus64.out_ready = 1'b1;
      bus64.in_valid  = (c < 8);
      bus64.in_a      = 64'(c);
      bus64.in_b      = 64'(c) << 32;
      bus64.in_sub    = 1'b0;
      bus64.in_cin    = 1'b0;
      @(negedge clk);
      exp_v = (c >= 2) && (c < 10);
      check_value("b2b_rdy", bus64.in_ready, 1);
      check_value("b2b_valid", bus64.out_valid, exp_v);
      if (bus64.out_valid) begin
        kk = 64'(k);
        check_value("b2b_sum", bus64.out_sum, kk + (kk << 32));
        $display("txn b2b beat=%0d sum=%h", k, bus64.out_sum);
        k++;
      end
    end
    check_value("b2b_count", k, 8);

    // Stall: out_ready low for cycles 3..5
    for (int i = 0; i < 4; i++) begin
      sa[i] = {$urandom, $urandom}; sb[i] = {$urandom, $urandom};
      ss[i] = $urandom_range(0, 1) != 0; sc[i] = $urandom_range(0, 1) != 0;
      se[i] = ref_model(64, {64'd0, sa[i]}, {64'd0, sb[i]}, ss[i], sc[i]);
    end
    idx = 0; k = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      bus64.in_valid  = (idx < 4);
      if (idx < 4) begin
        bus64.in_a = sa[idx]; bus64.in_b = sb[idx]; bus64.in_sub = ss[idx]; bus64.in_cin = sc[idx];
      end
      bus64.out_ready = !(c >= 3 && c <= 5);
      @(negedge clk);
      if (c >= 3 && c <= 5) begin
        check_value("stall_rdy", bus64.in_ready, 0);
        check_value("stall_valid", bus64.out_valid, 1);
      end
      if (bus64.out_valid) begin
        if (k < 4) begin
          check_value("stall_sum", bus64.out_sum, se[k][63:0]);
          check_value("stall_cout", bus64.out_cout, se[k][129]);
          check_value("stall_ovf", bus64.out_ovf, se[k][128]);
          if (bus64.out_ready) begin
            $display("txn stall beat=%0d sum=%h", k, bus64.out_sum);
            k++;
          end
        end else begin
          check_value("stall_extra", bus64.out_valid, 0);
        end
      end
      if (bus64.in_valid && bus64.in_ready) idx++;
    end
    check_value("stall_sent", idx, 4);
    check_value("stall_recv", k, 4);

    // Reset mid-flight
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      bus64.out_ready = 1'b1;
      bus64.in_valid  = (c < 2);
      bus64.in_a      = 64'h1234_5678_9ABC_DEF0;
      bus64.in_b      = 64'h0F0F_0F0F_0F0F_0F0F;
      bus64.in_sub    = 1'b0;
      bus64.in_cin    = 1'b0;
      rst64           = (c == 2);
      @(negedge clk);
      if (c == 3) begin
        check_value("rstmf_sum", bus64.out_sum, 0);
        check_value("rstmf_cout", bus64.out_cout, 0);
        check_value("rstmf_ovf", bus64.out_ovf, 0);
        check_value("rstmf_rdy", bus64.in_ready, 1);
      end
      if (c >= 3) check_value("rstmf_valid", bus64.out_valid, 0);
    end
    $display("txn reset_midflight done");

    w = 0;
    while (!(g_sweep[0].done && g_sweep[1].done) && w < 5000) begin
      @(posedge clk);
      w++;
    end
    check_value("sweep_done", g_sweep[0].done && g_sweep[1].done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
